// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and defaults for the instruction/data RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Which master owns a granted access (also encodes last_winner)
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // Response register: one pending response per grant, returned next cycle
    typedef struct packed {
        logic   valid;  // a grant happened last cycle
        owner_e owner;  // port that receives rvalid
        logic   err;    // address fell outside the RAM window
        logic   write;  // store: rvalid only, rdata forced to 0
    } rsp_t;

    localparam int unsigned c_mem_size_default  = 65536;
    localparam logic [31:0] c_mem_start_default = 32'h0000_0000;

    localparam rsp_t c_rsp_idle = '{valid: 1'b0, owner: OWNER_INSTR, err: 1'b0, write: 1'b0};

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational two-way picker, req[0]=instr, req[1]=data,
//            one-hot grant out. Tie policy selected by MEM_ARB_ROUND_ROBIN_EN:
//            defined   -> grant the port that did not win last time
//            undefined -> instruction port always wins ties
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_winner,
    output logic [1:0] gnt
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the history bit; keep it visibly consumed
    logic w_unused_last_winner;
    assign w_unused_last_winner = last_winner;
`endif

    // Single requests pass straight through; ties resolved by policy
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gnt = (last_winner == OWNER_DATA) ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Arbitrates Ibex instruction and data OBI ports onto one
//            single-port RAM with one-cycle read latency. Zero-latency grant,
//            response exactly one cycle after grant, saturating grant counters.
//            Tie policy: define MEM_ARB_ROUND_ROBIN_EN for round-robin,
//            otherwise fixed priority (instruction port wins).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = c_mem_size_default,
    parameter logic [31:0] MEM_START = c_mem_start_default,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             instr_req,
    input  logic [31:0]      instr_addr,
    output logic             instr_gnt,
    output logic             instr_rvalid,
    output logic             instr_err,
    output logic [31:0]      instr_rdata,
    input  logic             data_req,
    input  logic             data_we,
    input  logic [3:0]       data_be,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_gnt,
    output logic             data_rvalid,
    output logic             data_err,
    output logic [31:0]      data_rdata,
    output logic             mem_req,
    output logic             mem_write,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] instr_grant_cnt,
    output logic [CNT_W-1:0] data_grant_cnt
);

    localparam logic [31:0]      c_offset_mask = 32'(MEM_SIZE - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    logic             w_any_gnt;
    logic [31:0]      w_addr;
    logic             w_in_range;
    logic [31:0]      w_rsp_data;
    owner_e           r_last_winner;
    rsp_t             r_rsp;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_data_cnt;

    assign w_req = {data_req, instr_req};

    mem_arb_pick u_pick (
        .req         (w_req),
        .last_winner (r_last_winner),
        .gnt         (w_gnt)
    );

    assign instr_gnt  = w_gnt[0];
    assign data_gnt   = w_gnt[1];
    assign w_any_gnt  = |w_gnt;
    assign w_addr     = w_gnt[1] ? data_addr : instr_addr;
    assign w_in_range = ((w_addr & ~c_offset_mask) == MEM_START);

    // RAM command from the winner; all zero when idle or out of window
    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_any_gnt && w_in_range) begin
            mem_req  = 1'b1;
            mem_addr = w_addr;
            if (w_gnt[1]) begin
                mem_write = data_we;
                mem_be    = data_be;
                mem_wdata = data_we ? data_wdata : 32'h0;
            end else begin
                mem_be    = 4'hF;
            end
        end
    end

    // Capture one response per grant; reset drops anything pending
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_rsp <= c_rsp_idle;
        end else begin
            r_rsp.valid <= w_any_gnt;
            r_rsp.owner <= w_gnt[1] ? OWNER_DATA : OWNER_INSTR;
            r_rsp.err   <= w_any_gnt & ~w_in_range;
            r_rsp.write <= w_gnt[1] & data_we;
        end
    end

    // Remember who won last so round-robin can alternate on ties
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_last_winner <= OWNER_DATA;
        end else if (w_any_gnt) begin
            r_last_winner <= w_gnt[1] ? OWNER_DATA : OWNER_INSTR;
        end
    end

    // Saturating per-port grant counters
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_instr_cnt <= '0;
            r_data_cnt  <= '0;
        end else begin
            if (w_gnt[0] && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + c_cnt_one;
            if (w_gnt[1] && (r_data_cnt  != '1)) r_data_cnt  <= r_data_cnt  + c_cnt_one;
        end
    end

    // RAM data is live the cycle after the access; errors and stores return 0
    assign w_rsp_data = (r_rsp.valid && !r_rsp.err && !r_rsp.write) ? mem_rdata : 32'h0;

    assign instr_rvalid = r_rsp.valid && (r_rsp.owner == OWNER_INSTR);
    assign data_rvalid  = r_rsp.valid && (r_rsp.owner == OWNER_DATA);
    assign instr_err    = instr_rvalid & r_rsp.err;
    assign data_err     = data_rvalid  & r_rsp.err;
    assign instr_rdata  = instr_rvalid ? w_rsp_data : 32'h0;
    assign data_rdata   = data_rvalid  ? w_rsp_data : 32'h0;

    assign instr_grant_cnt = r_instr_cnt;
    assign data_grant_cnt  = r_data_cnt;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master to one-slave arbiter between the Ibex instruction and data ports and the single-port testbench RAM. Accepts OBI-style requests from both ports, issues at most one RAM access per cycle, and steers the RAM's one-cycle-latency read data back to the owning port with `rvalid`/`err`. Replaces the ad-hoc combinational arbitration in the verification environment with a synthesizable, individually testable block.

## Interface
- `MEM_SIZE`, 65536, RAM window size in bytes, power of two
- `MEM_START`, 32'h0, window base, aligned to `MEM_SIZE`
- `CNT_W`, 16, width of the per-port grant counters
- `clk_sys` in 1: the block's only clock
- `rst_sys_n` in 1: reset, asynchronous and active-low
- `instr_req` / `instr_addr[31:0]` in: instruction fetch request
- `instr_gnt` / `instr_rvalid` / `instr_err` out 1: fetch handshake
- `instr_rdata` out 32: fetch data
- `data_req` / `data_we` in 1; `data_be` in 4; `data_addr` / `data_wdata` in 32: load/store request
- `data_gnt` / `data_rvalid` / `data_err` out 1; `data_rdata` out 32: load/store handshake
- `mem_req` / `mem_write` out 1; `mem_be` out 4; `mem_addr` / `mem_wdata` out 32: RAM command
- `mem_rdata` in 32: RAM read data, valid the cycle after `mem_req`
- `instr_grant_cnt` / `data_grant_cnt` out `CNT_W`: saturating grant counts

## Operation
- Each cycle, select at most one winner among asserted `instr_req`/`data_req`; assert that port's `gnt` combinationally in the same cycle. The loser sees `gnt`=0 and holds its request.
- In range (`(addr & ~(MEM_SIZE-1)) == MEM_START`): drive `mem_*` from the winner. Out of range: no `mem_req`; response carries `err`=1 and `rdata`=0.
- Response register: `{valid, owner, err}` captured on every grant; next cycle assert `owner`'s `rvalid` (and `err`); `rdata` = `mem_rdata` for in-range, 0 for error. Writes also receive `rvalid` (rdata 0).
- Non-owner `rdata` is 0; `mem_*` outputs are 0 when idle.
- Counters: increment the winner's counter per grant; saturate at all-ones.
- Priority state: 1-bit `last_winner` (0=instr, 1=data), updated on each grant.

## Timing
- Reset: all outputs 0, response register invalid, `last_winner`=1 (so instr wins the first tie), counters 0.
- Grant latency 0 cycles; response latency exactly 1 cycle after grant; throughput one grant per cycle, back-to-back allowed.
- A port receives at most one `rvalid` per grant, in grant order.
- Reset asserted mid-transaction: pending `rvalid` is dropped; no response appears after `rst_sys_n` deasserts.
- A request dropped without grant is discarded, with no side effects.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the port that is not `last_winner`. Single requests are always granted.
- Undefined: fixed priority, instr always wins ties. `last_winner` is still maintained but unused.

## Structure
- Shared package `mem_arb_pkg`: `typedef enum logic {OWNER_INSTR, OWNER_DATA} owner_e`, the response-register struct, default `MEM_SIZE`/`MEM_START` constants.
- One sub-module `mem_arb_pick`: combinational two-way picker (`req[1:0]`, `last_winner`) -> one-hot grant, with the macro-controlled policy.

## Test plan
- Instr only, `instr_addr`=0x10, `mem_rdata`=0xDEADBEEF -> `instr_gnt` in cycle N, `mem_req`/`mem_addr`=0x10 in N, `instr_rvalid` with rdata 0xDEADBEEF in N+1, `err`=0.
- Data store `addr`=0x20, `be`=4'b0011, `wdata`=0x1234 -> `mem_write`=1, `mem_be`=0011 in N, `data_rvalid` in N+1, `data_rdata`=0.
- Both requesting for 4 cycles, round-robin build -> grants I,D,I,D and counters 2/2. Fixed-priority build -> I,I,I,I, then data is granted when instr drops.
- Data load at `addr`=0x0001_0000 -> `data_gnt`=1, `mem_req`=0, next cycle `data_rvalid`=1, `data_err`=1, rdata 0.
- Grant in cycle N, `rst_sys_n` low in N+1 before the clock edge -> no `rvalid` either port, counters 0 after reset.
- Force `instr_grant_cnt` near max with 2^CNT_W+3 fetches (CNT_W=4 override) -> counter holds 4'hF.
